// File: rtl/rs_alu_issue_ctrl_pkg.sv
// rtl/rs_alu_issue_ctrl_pkg.sv - shared core constants for the ALU reservation-station issue control
package rs_alu_issue_ctrl_pkg;

  // Reservation-station sizing defaults; RS_SEL_DEFAULT must equal log2(RS_ENT_DEFAULT)
  localparam int RS_ENT_DEFAULT = 8;
  localparam int RS_SEL_DEFAULT = 3;

  // Neighbouring core-wide constants kept in the same header
  localparam int RRF_SEL      = 6;
  localparam int DATA_LEN     = 32;
  localparam int ALU_OP_WIDTH = 4;

endpackage

// File: rtl/rs_alu_issue_ctrl_age_matrix.sv
// rtl/rs_alu_issue_ctrl_age_matrix.sv - age matrix picking the oldest ready entry (built under RS_AGE_ORDER_EN)
module rs_age_matrix #(
  parameter int RS_ENT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_kill,
  input  logic [RS_ENT-1:0] i_busy,
  input  logic [RS_ENT-1:0] i_alloc_oh,
  input  logic [RS_ENT-1:0] i_cand,
  output logic [RS_ENT-1:0] o_oldest
);

  // r_age[i][j] = 1 means entry j is older than entry i
  logic [RS_ENT-1:0] r_age [RS_ENT];

  // New entry is younger than every occupant; its column is wiped so stale bits cannot make it look older
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RS_ENT; i++) r_age[i] <= '0;
    end else if (i_kill) begin
      for (int i = 0; i < RS_ENT; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < RS_ENT; i++) begin
        for (int j = 0; j < RS_ENT; j++) begin
          if (i_alloc_oh[i])      r_age[i][j] <= i_busy[j];
          else if (i_alloc_oh[j]) r_age[i][j] <= 1'b0;
        end
      end
    end
  end

  // A candidate is oldest when no other candidate is older than it
  always_comb begin
    o_oldest = '0;
    for (int i = 0; i < RS_ENT; i++) begin
      o_oldest[i] = i_cand[i] & ~(|(r_age[i] & i_cand));
    end
  end

endmodule

// File: rtl/rs_alu_issue_ctrl.sv
// rtl/rs_alu_issue_ctrl.sv - ALU reservation-station allocate/issue control (age ordering under RS_AGE_ORDER_EN)
module rs_alu_issue_ctrl
  import rs_alu_issue_ctrl_pkg::*;
#(
  parameter int RS_ENT = RS_ENT_DEFAULT,
  parameter int RS_SEL = RS_SEL_DEFAULT
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dp_req_i,
  input  logic              kill_i,
  input  logic [RS_ENT-1:0] ready_i,
  input  logic              exe_ready_i,
  output logic [RS_ENT-1:0] busy_o,
  output logic [RS_ENT-1:0] we_o,
  output logic              dp_stall_o,
  output logic              issue_valid_o,
  output logic [RS_SEL-1:0] issue_idx_o
);

  logic [RS_ENT-1:0] r_busy;
  logic [RS_ENT-1:0] w_we;
  logic [RS_ENT-1:0] w_cand;
  logic [RS_ENT-1:0] w_pick;
  logic [RS_ENT-1:0] w_issue_oh;
  logic [RS_SEL-1:0] w_free_idx;
  logic [RS_SEL-1:0] w_issue_idx;
  logic              w_full;
  logic              w_alloc;
  logic              w_issue;

  // Shared lowest-set-bit encoder used for both the free list and the issue pick
  function automatic logic [RS_SEL-1:0] lowest_idx(input logic [RS_ENT-1:0] v);
    lowest_idx = '0;
    for (int i = RS_ENT - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = i[RS_SEL-1:0];
    end
  endfunction

  assign w_cand = r_busy & ready_i;

`ifdef RS_AGE_ORDER_EN
  rs_age_matrix #(
    .RS_ENT(RS_ENT)
  ) u_age (
    .clk       (clk_i),
    .rst       (reset_i),
    .i_kill    (kill_i),
    .i_busy    (r_busy),
    .i_alloc_oh(w_we),
    .i_cand    (w_cand),
    .o_oldest  (w_pick)
  );
`else
  assign w_pick = w_cand;
`endif

  // Allocation of the lowest free entry; gated by reset so nothing is written while it is held
  always_comb begin
    w_full     = &r_busy;
    w_free_idx = lowest_idx(~r_busy);
    w_alloc    = dp_req_i & ~w_full & ~kill_i & ~reset_i;
    w_we       = '0;
    if (w_alloc) w_we[w_free_idx] = 1'b1;
  end

  // Issue the selected candidate when the ALU can take it and no flush is in progress
  always_comb begin
    w_issue     = exe_ready_i & (|w_cand) & ~kill_i;
    w_issue_idx = lowest_idx(w_pick);
    w_issue_oh  = '0;
    if (w_issue) w_issue_oh[w_issue_idx] = 1'b1;
  end

  // Busy bits: set on allocation, clear on issue, all cleared by a flush
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_busy <= '0;
    else if (kill_i) r_busy <= '0;
    else             r_busy <= (r_busy & ~w_issue_oh) | w_we;
  end

  assign busy_o        = r_busy;
  assign we_o          = w_we;
  assign dp_stall_o    = dp_req_i & w_full;
  assign issue_valid_o = w_issue;
  assign issue_idx_o   = w_issue ? w_issue_idx : '0;

endmodule

// File: doc/rs_alu_issue_ctrl.md
RS_ALU_ISSUE_CTRL -- requirements
Module: rs_alu_issue_ctrl

Interface
REQ-001 SHALL have parameter RS_ENT, default 8: number of ALU reservation-station entries controlled (power of two, 2..16).
REQ-002 SHALL have parameter RS_SEL, default 3: index width, equal to log2(RS_ENT).
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 dp_req_i  input  1  dispatch stage requests one entry this cycle.
REQ-006 kill_i  input  1  pipeline flush; invalidates all entries.
REQ-007 ready_i  input  RS_ENT  per-entry operands-ready flag, driven by each entry's ready_o.
REQ-008 exe_ready_i  input  1  ALU accepts an issued instruction this cycle.
REQ-009 busy_o  output  RS_ENT  per-entry busy flag, drives each entry's busy_i.
REQ-010 we_o  output  RS_ENT  one-hot write enable, drives each entry's we_i.
REQ-011 dp_stall_o  output  1  no free entry; the dispatch request is refused.
REQ-012 issue_valid_o  output  1  an entry is issued this cycle.
REQ-013 issue_idx_o  output  RS_SEL  index of the issued entry; operand mux select for the ALU.

Function
REQ-014 Allocation SHALL be the lowest-index entry with busy=0; we_o SHALL be the combinational one-hot of that entry when dp_req_i=1, no stall and kill_i=0, else all zero.
REQ-015 dp_stall_o SHALL equal dp_req_i AND (all busy_o=1).
REQ-016 The allocated entry's busy bit SHALL set at the next rising edge; an entry is therefore visible to issue no earlier than one cycle after its write.
REQ-017 Issue candidates SHALL be entries with busy=1 AND ready_i=1; issue_valid_o SHALL equal exe_ready_i AND (any candidate) AND NOT kill_i.
REQ-018 issue_idx_o SHALL select the oldest candidate (see REQ-025); when issue_valid_o=0 it SHALL hold 0.
REQ-019 The issued entry's busy bit SHALL clear at the next rising edge; the freed entry is allocatable from that edge on, never in the issuing cycle.
REQ-020 Allocation and issue in the same cycle SHALL both take effect, on distinct entries.
REQ-021 kill_i=1 SHALL suppress we_o and issue_valid_o in that cycle and clear every busy bit and all age state at the next edge.
REQ-022 At most one allocation and one issue SHALL occur per cycle.

Reset
REQ-023 While reset_i=1, asynchronously: busy_o=0, age state cleared, we_o=0, dp_stall_o=0, issue_valid_o=0, issue_idx_o=0.
REQ-024 Reset asserted mid-operation SHALL discard all outstanding entries; after release the first dispatch SHALL receive entry 0.

Configuration
REQ-025 With RS_AGE_ORDER_EN defined, an RS_ENT x RS_ENT age matrix SHALL be kept: on allocating entry k, row k is set to the current busy vector (k younger than all occupants), and column k of every other row is cleared; the oldest candidate is the one with no older candidate.
REQ-026 Without RS_AGE_ORDER_EN, no age state SHALL exist and issue SHALL select the lowest-index candidate.

Structure
REQ-027 RS_ENT and RS_SEL defaults SHALL reside in the shared consts header beside RRF_SEL, DATA_LEN and ALU_OP_WIDTH.
REQ-028 The age matrix and its oldest-candidate select SHALL be a sub-module, rs_age_matrix, instantiated only under RS_AGE_ORDER_EN.
REQ-029 The lowest-free and lowest-ready priority encoders SHALL be one shared function or generate block, not a separate module.

Verification
REQ-030 Reset, then dp_req_i=1 for 8 cycles -> we_o = 0x01, 0x02 … 0x80 in successive cycles; busy_o=0xFF; 9th request -> dp_stall_o=1, we_o=0.
REQ-031 Full, ready_i=0x10, exe_ready_i=1 -> issue_valid_o=1, issue_idx_o=4; next cycle busy_o=0xEF; dp_req_i then -> we_o=0x10.
REQ-032 With RS_AGE_ORDER_EN: allocate entries 0,1,2; issue 0; allocate again (gets 0); ready_i=0x07 -> issue_idx_o=1 (oldest), not 0; without the macro -> issue_idx_o=0.
REQ-033 Same cycle: dp_req_i=1, busy_o=0x7F, entry 3 ready, exe_ready_i=1 -> we_o=0x80, issue_idx_o=3; next cycle busy_o=0xF7.
REQ-034 busy_o=0xFF, kill_i=1 with dp_req_i=1 and ready_i=0xFF -> we_o=0, issue_valid_o=0; next cycle busy_o=0x00.
REQ-035 Entry ready, exe_ready_i=0 for 3 cycles -> issue_valid_o=0 and busy unchanged; exe_ready_i=1 -> issue in that cycle.
